// File: rtl/udp_tx_req_arbiter.sv
// Round-robin arbiter feeding one UDP send port from CH_NUM requesters, with
// length rejection, send timeout, stretched completion pulses and an inter-frame gap.
module udp_tx_req_arbiter #(
  parameter int CH_NUM  = 4,
  parameter int DATA_W  = 961,
  parameter int LEN_W   = 16,
  parameter int MAX_LEN = 120,
  parameter int STRETCH = 16,
  parameter int TIMEOUT = 4095,
  parameter int IFG     = 12,
  localparam int ID_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     rgmii_clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        ch_valid,
  input  logic [CH_NUM*DATA_W-1:0] ch_data,
  input  logic [CH_NUM*LEN_W-1:0]  ch_length,
  output logic [CH_NUM-1:0]        ch_done,
  output logic [CH_NUM-1:0]        ch_err,
  output logic                     eng_send_valid,
  output logic [DATA_W-1:0]        eng_send_data,
  output logic [LEN_W-1:0]         eng_send_length,
  input  logic                     eng_send_ready,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  localparam int ST_W     = $clog2(STRETCH + 1);
  localparam int TO_W     = $clog2(TIMEOUT + 1);
  localparam int GP_W     = (IFG > 0) ? $clog2(IFG + 1) : 1;
  localparam int GAP_LAST = (IFG > 0) ? IFG - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam state_t POST_ST = (IFG == 0) ? S_IDLE : S_GAP;

  state_t              state_r, state_nxt_s;
  logic [ID_W-1:0]     ptr_r, grant_id_r, winner_s;
  logic [ST_W-1:0]     st_cnt_r [CH_NUM];
  logic [TO_W-1:0]     tmo_cnt_r;
  logic [GP_W-1:0]     gap_cnt_r;
  logic                ready_d_r, busy_r, eng_send_valid_r;
  logic [CH_NUM-1:0]   ch_done_r, ch_err_r, elig_s;
  logic [DATA_W-1:0]   eng_send_data_r, win_data_s;
  logic [LEN_W-1:0]    eng_send_length_r, win_len_s;
  logic                found_s, bad_len_s, accept_s, tmo_hit_s, gap_end_s;
  logic                grant_s, abort_s;

  assign ch_done         = ch_done_r;
  assign ch_err          = ch_err_r;
  assign eng_send_valid  = eng_send_valid_r;
  assign eng_send_data   = eng_send_data_r;
  assign eng_send_length = eng_send_length_r;
  assign grant_id        = grant_id_r;
  assign busy            = busy_r;

  // Winner search, request qualification and next-state decode
  always_comb begin
    found_s  = 1'b0;
    winner_s = {ID_W{1'b0}};
    for (int i = 0; i < CH_NUM; i++) begin
      elig_s[i] = ch_valid[i] && (st_cnt_r[i] == {ST_W{1'b0}});
    end
    for (int k = 0; k < CH_NUM; k++) begin
      if (!found_s && elig_s[(int'(ptr_r) + k) % CH_NUM]) begin
        found_s  = 1'b1;
        winner_s = ID_W'((int'(ptr_r) + k) % CH_NUM);
      end else begin
        found_s  = found_s;
      end
    end
    win_len_s   = ch_length[int'(winner_s)*LEN_W +: LEN_W];
    win_data_s  = ch_data[int'(winner_s)*DATA_W +: DATA_W];
    bad_len_s   = (win_len_s == {LEN_W{1'b0}}) || (win_len_s > LEN_W'(MAX_LEN));
    // ready must be seen rising while in SEND; a level left over from before does not count
    accept_s    = (state_r == S_SEND) && eng_send_ready && !ready_d_r;
    tmo_hit_s   = (tmo_cnt_r == TO_W'(TIMEOUT - 1));
    gap_end_s   = (gap_cnt_r == GP_W'(GAP_LAST));
    grant_s     = 1'b0;
    abort_s     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (found_s) begin
          grant_s     = 1'b1;
          state_nxt_s = bad_len_s ? POST_ST : S_SEND;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SEND: begin
        if (accept_s) begin
          state_nxt_s = POST_ST;
        end else if (tmo_hit_s) begin
          abort_s     = 1'b1;
          state_nxt_s = POST_ST;
        end else begin
          state_nxt_s = S_SEND;
        end
      end
      S_GAP: begin
        if (gap_end_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_GAP;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant latch, engine outputs, timeout and gap counters
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      ptr_r             <= {ID_W{1'b0}};
      grant_id_r        <= {ID_W{1'b0}};
      eng_send_valid_r  <= 1'b0;
      eng_send_data_r   <= {DATA_W{1'b0}};
      eng_send_length_r <= {LEN_W{1'b0}};
      tmo_cnt_r         <= {TO_W{1'b0}};
      gap_cnt_r         <= {GP_W{1'b0}};
      ready_d_r         <= 1'b0;
      busy_r            <= 1'b0;
      ch_err_r          <= {CH_NUM{1'b0}};
    end else begin
      ready_d_r <= eng_send_ready;
      busy_r    <= (state_nxt_s != S_IDLE);
      ch_err_r  <= {CH_NUM{1'b0}};
      if (grant_s) begin
        grant_id_r        <= winner_s;
        eng_send_data_r   <= win_data_s;
        eng_send_length_r <= win_len_s;
        ptr_r             <= (winner_s == ID_W'(CH_NUM - 1)) ? {ID_W{1'b0}} : winner_s + ID_W'(1);
        tmo_cnt_r         <= {TO_W{1'b0}};
        gap_cnt_r         <= {GP_W{1'b0}};
        eng_send_valid_r  <= !bad_len_s;
        if (bad_len_s) begin
          ch_err_r[winner_s] <= 1'b1;
        end
      end else if (accept_s || abort_s) begin
        eng_send_valid_r <= 1'b0;
        gap_cnt_r        <= {GP_W{1'b0}};
        if (abort_s) begin
          ch_err_r[grant_id_r] <= 1'b1;
        end
      end else if (state_r == S_SEND) begin
        tmo_cnt_r <= tmo_cnt_r + TO_W'(1);
      end else if (state_r == S_GAP) begin
        gap_cnt_r <= gap_cnt_r + GP_W'(1);
      end
    end
  end

  // Per-channel done stretchers; a busy stretcher also blocks re-grant of that channel
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        st_cnt_r[i] <= {ST_W{1'b0}};
      end
      ch_done_r <= {CH_NUM{1'b0}};
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (accept_s && (grant_id_r == ID_W'(i))) begin
          st_cnt_r[i]  <= ST_W'(STRETCH);
          ch_done_r[i] <= 1'b1;
        end else if (st_cnt_r[i] != {ST_W{1'b0}}) begin
          st_cnt_r[i]  <= st_cnt_r[i] - ST_W'(1);
          ch_done_r[i] <= (st_cnt_r[i] != ST_W'(1));
        end else begin
          ch_done_r[i] <= 1'b0;
        end
      end
    end
  end

endmodule
